// File: rtl/duty_slew_ctrl.sv
// duty_slew_ctrl: slew-rate-limited duty command generator; target clamp enabled by DUTY_SLEW_CLAMP_EN
module duty_slew_ctrl #(
  parameter int DW = 8,
  parameter int PRESC_W = 16,
  parameter int STEP_W = 4,
  parameter logic [DW-1:0] MIN_DUTY = 8'd0,
  parameter logic [DW-1:0] MAX_DUTY = 8'd230
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_tgt_valid,
  input  logic [DW-1:0]      i_tgt_duty,
  output logic               o_tgt_ready,
  input  logic [PRESC_W-1:0] i_rate_div,
  input  logic [STEP_W-1:0]  i_step,
  input  logic               i_fault,
  input  logic               i_fault_clr,
  output logic [DW-1:0]      o_duty,
  output logic               o_settled,
  output logic               o_busy,
  output logic               o_fault
);
  typedef enum logic [1:0] {IDLE, RAMP, HOLD, FAULT} state_t;
  state_t state, state_n;
  logic [DW-1:0] duty, duty_n, tgt, tgt_n, tgt_in, step_d;
  logic [PRESC_W-1:0] presc, presc_n;
  logic [DW:0] diff;
  logic tick, acc;
  assign o_tgt_ready = ~rst & i_en & ~i_fault & (state != FAULT);
  assign acc = i_tgt_valid & o_tgt_ready;
  // >= keeps the wrap safe if i_rate_div is lowered below the running count
  assign tick = presc >= i_rate_div;
  assign step_d = {{(DW-STEP_W){1'b0}}, (i_step == '0) ? STEP_W'(1) : i_step};
  assign diff = (tgt >= duty) ? {1'b0, tgt} - {1'b0, duty} : {1'b0, duty} - {1'b0, tgt};
`ifdef DUTY_SLEW_CLAMP_EN
  assign tgt_in = (i_tgt_duty > MAX_DUTY) ? MAX_DUTY : (i_tgt_duty < MIN_DUTY) ? MIN_DUTY : i_tgt_duty;
`else
  assign tgt_in = i_tgt_duty;
`endif
  assign o_duty = duty;
  assign o_settled = state == HOLD;
  assign o_busy = state == RAMP;
  assign o_fault = state == FAULT;
  // state, duty, target and prescaler registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      duty <= '0;
      tgt <= '0;
      presc <= '0;
    end else begin
      state <= state_n;
      duty <= duty_n;
      tgt <= tgt_n;
      presc <= presc_n;
    end
  end
  // next state in priority order: fault, fault hold/clear, disable, accept, step
  always_comb begin
    state_n = state;
    duty_n = duty;
    tgt_n = tgt;
    presc_n = tick ? '0 : presc + 1'b1;
    if (i_fault) begin
      state_n = FAULT;
      duty_n = '0;
      tgt_n = '0;
      presc_n = '0;
    end else if (state == FAULT) begin
      presc_n = '0;
      state_n = i_fault_clr ? IDLE : FAULT;
    end else if (!i_en) begin
      state_n = IDLE;
      duty_n = '0;
      tgt_n = '0;
      presc_n = '0;
    end else if (acc) begin
      tgt_n = tgt_in;
      presc_n = '0;
      state_n = (state == HOLD && tgt_in == duty) ? HOLD : RAMP;
    end else if (state == RAMP && tick) begin
      state_n = (diff <= {1'b0, step_d}) ? HOLD : RAMP;
      duty_n = (diff <= {1'b0, step_d}) ? tgt : (tgt > duty) ? duty + step_d : duty - step_d;
    end
  end
endmodule

// File: tb/tb_duty_slew_ctrl.sv
// tb_duty_slew_ctrl: scoreboard bench for duty_slew_ctrl output-change sequences
module tb_duty_slew_ctrl;
  logic clk = 0, rst = 1, i_en = 0, i_tgt_valid = 0, i_fault = 0, i_fault_clr = 0;
  logic [7:0] i_tgt_duty = '0;
  logic [15:0] i_rate_div = '0;
  logic [3:0] i_step = '0;
  logic o_tgt_ready, o_settled, o_busy, o_fault;
  logic [7:0] o_duty;
  int cyc = 0, checks = 0, errors = 0;
  bit mon_on = 0;
  typedef struct {int c; logic [7:0] d; logic s, b, f;} exp_t;
  exp_t q[$];

  duty_slew_ctrl dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_tgt_valid(i_tgt_valid), .i_tgt_duty(i_tgt_duty),
    .o_tgt_ready(o_tgt_ready), .i_rate_div(i_rate_div), .i_step(i_step), .i_fault(i_fault),
    .i_fault_clr(i_fault_clr), .o_duty(o_duty), .o_settled(o_settled), .o_busy(o_busy), .o_fault(o_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic push(input int c, input int d, input logic s, input logic b, input logic f);
    exp_t e;
    e.c = c; e.d = d[7:0]; e.s = s; e.b = b; e.f = f;
    q.push_back(e);
  endtask

  // Expected trace of a ramp: RAMP entry at t0, then one step every per cycles
  task automatic ramp_exp(input int t0, input int start, input int tgt, input int step, input int per);
    int d = start, k = 0;
    push(t0, start, 0, 1, 0);
    while (d != tgt) begin
      k++;
      if ((tgt > d ? tgt - d : d - tgt) <= step) d = tgt;
      else d = tgt > d ? d + step : d - step;
      push(t0 + k * per, d, d == tgt, d != tgt, 0);
    end
  endtask

  task automatic offer(input int d, output int t);
    i_tgt_valid = 1;
    i_tgt_duty = d[7:0];
    t = cyc + 1;
    #1 chk("ready_on_offer", int'(o_tgt_ready), 1);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every change of the observable outputs pops one expectation
  initial begin
    logic [10:0] prev, cur;
    exp_t e;
    wait (mon_on);
    prev = {o_duty, o_settled, o_busy, o_fault};
    forever begin
      @(negedge clk);
      cur = {o_duty, o_settled, o_busy, o_fault};
      if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL mon_unexpected: got cyc=%0d duty=%0d sbf=%b, want no change", cyc, o_duty, cur[2:0]);
        end else begin
          e = q.pop_front();
          if (e.c != cyc || e.d !== o_duty || e.s !== o_settled || e.b !== o_busy || e.f !== o_fault) begin
            errors++;
            $display("FAIL mon_change: got cyc=%0d duty=%0d sbf=%b%b%b, want cyc=%0d duty=%0d sbf=%b%b%b",
                     cyc, o_duty, o_settled, o_busy, o_fault, e.c, e.d, e.s, e.b, e.f);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int t, a;
    repeat (3) @(negedge clk);
    i_en = 1;
    #1 chk("reset_ready", int'(o_tgt_ready), 0);
    chk("reset_duty", int'(o_duty), 0);
    chk("reset_flags", int'({o_settled, o_busy, o_fault}), 0);
    @(negedge clk);
    rst = 0;
    mon_on = 1;
    @(negedge clk);
    chk("idle_ready_en", int'(o_tgt_ready), 1);
    // basic ramp: rate_div=3, step=4, target 20
    i_rate_div = 3; i_step = 4;
    offer(20, t);
    push(t, 0, 0, 1, 0); push(t+4, 4, 0, 1, 0); push(t+8, 8, 0, 1, 0);
    push(t+12, 12, 0, 1, 0); push(t+16, 16, 0, 1, 0); push(t+20, 20, 1, 0, 0);
    @(negedge clk); i_tgt_valid = 0;
    drain();
    // partial final step down, rate_div=0, step=7
    i_rate_div = 0; i_step = 7;
    offer(3, t);
    push(t, 20, 0, 1, 0); push(t+1, 13, 0, 1, 0); push(t+2, 6, 0, 1, 0); push(t+3, 3, 1, 0, 0);
    @(negedge clk); i_tgt_valid = 0;
    drain();
    // step=0 behaves as 1
    i_step = 0;
    offer(6, t);
    push(t, 3, 0, 1, 0); push(t+1, 4, 0, 1, 0); push(t+2, 5, 0, 1, 0); push(t+3, 6, 1, 0, 0);
    @(negedge clk); i_tgt_valid = 0;
    drain();
    // same target in HOLD stays in HOLD
    offer(6, t);
    @(negedge clk); i_tgt_valid = 0;
    drain();
    // disable returns to IDLE
    i_en = 0;
    push(cyc+1, 0, 0, 0, 0);
    @(negedge clk); i_en = 1;
    drain();
    // retarget mid-ramp: 0->100 step 10 rate_div=1, at 40 retarget 30
    i_rate_div = 1; i_step = 10;
    offer(100, t);
    push(t, 0, 0, 1, 0); push(t+2, 10, 0, 1, 0); push(t+4, 20, 0, 1, 0);
    push(t+6, 30, 0, 1, 0); push(t+8, 40, 0, 1, 0);
    @(negedge clk); i_tgt_valid = 0;
    wait_cyc(t+8);
    offer(30, a);
    push(a+2, 30, 1, 0, 0);
    @(negedge clk); i_tgt_valid = 0;
    drain();
    // fault during RAMP, clear ignored while fault present
    i_rate_div = 3; i_step = 4;
    offer(60, t);
    push(t, 30, 0, 1, 0); push(t+4, 34, 0, 1, 0);
    @(negedge clk); i_tgt_valid = 0;
    wait_cyc(t+5);
    i_fault = 1;
    push(cyc+1, 0, 0, 0, 1);
    #1 chk("fault_ready", int'(o_tgt_ready), 0);
    repeat (2) @(negedge clk);
    i_fault_clr = 1;
    repeat (3) @(negedge clk);
    chk("fault_clr_ignored", int'(o_fault), 1);
    i_fault = 0; i_fault_clr = 0;
    repeat (2) @(negedge clk);
    chk("fault_ready_cleared_req", int'(o_tgt_ready), 0);
    i_fault_clr = 1;
    push(cyc+1, 0, 0, 0, 0);
    @(negedge clk); i_fault_clr = 0;
    drain();
    // enable drop at duty 50 with a concurrent valid
    i_rate_div = 0; i_step = 10;
    offer(100, t);
    ramp_exp(t, 0, 50, 10, 1);
    q.pop_back();
    push(t+5, 50, 0, 1, 0);
    @(negedge clk); i_tgt_valid = 0;
    wait_cyc(t+5);
    i_en = 0; i_tgt_valid = 1; i_tgt_duty = 77;
    #1 chk("en_low_ready", int'(o_tgt_ready), 0);
    push(cyc+1, 0, 0, 0, 0);
    @(negedge clk); i_en = 1; i_tgt_valid = 0;
    drain();
    chk("en_low_not_accepted", int'(o_duty), 0);
    // reset mid-ramp
    offer(100, t);
    push(t, 0, 0, 1, 0); push(t+1, 10, 0, 1, 0); push(t+2, 20, 0, 1, 0);
    @(negedge clk); i_tgt_valid = 0;
    wait_cyc(t+2);
    rst = 1;
    push(cyc+1, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_ready", int'(o_tgt_ready), 0);
    rst = 0;
    drain();
    // top of range: clamped to MAX_DUTY or raw 255
    i_step = 15;
    offer(255, t);
`ifdef DUTY_SLEW_CLAMP_EN
    ramp_exp(t, 0, 230, 15, 1);
`else
    ramp_exp(t, 0, 255, 15, 1);
`endif
    @(negedge clk); i_tgt_valid = 0;
    drain();
`ifdef DUTY_SLEW_CLAMP_EN
    chk("clamp_settle", int'(o_duty), 230);
`else
    chk("raw_settle", int'(o_duty), 255);
`endif
    chk("final_settled", int'(o_settled), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
